syndrome_scheduler: RTL
=======================

// Module: syndrome_scheduler
// PURPOSE
//  Sequences one shared GF(2^8) syndrome engine over a stored RS(204,188) codeword to produce
//  all NSYN syndromes S_0..S_{NSYN-1}. Reads the codeword buffer, drives the engine per root,
//  writes each result into the syndrome register file and flags a non-zero syndrome set.
//  Sits between the de-interleaver output buffer and the key-equation solver.
// PARAMETERS
//  N          204  codeword length in bytes (address 0 = highest-degree coefficient)
//  NSYN       16   number of syndromes (2t)
//  RAM_LAT    1    codeword buffer read latency, cycles (1..3)
//  FIRST_ROOT 0    log of first root; syndrome i uses alpha^(FIRST_ROOT+i)
// PORTS
//  Clk           in   1  clock, all logic on rising edge
//  Reset         in   1  synchronous, active-high reset
//  start         in   1  begin computation; sampled in IDLE only
//  busy          out  1  high in every state except IDLE
//  done          out  1  one-cycle pulse, all NSYN syndromes written
//  nonzero_flag  out  1  OR of all syndromes of last run; valid with done, held to next start
//  cw_rd         out  1  codeword buffer read strobe
//  cw_addr       out  8  codeword buffer read address
//  cw_data       in   8  read data, valid RAM_LAT cycles after cw_rd
//  eng_clr       out  1  engine accumulator clear (S <= 0)
//  eng_en        out  1  engine update: S <= S*alpha^eng_alpha ^ eng_byte
//  eng_alpha     out  8  log of current root, (FIRST_ROOT+i) mod 255, stable per syndrome
//  eng_byte      out  8  byte fed to engine (cw_data pass-through)
//  eng_syn       in   8  engine accumulator, valid cycle after last eng_en
//  syn_wr        out  1  syndrome file write strobe
//  syn_waddr     out  4  syndrome index i
//  syn_wdata     out  8  syndrome value
// BEHAVIOUR
//  Reset: state IDLE, i=0; busy, done, nonzero_flag, cw_rd, eng_clr, eng_en, syn_wr = 0;
//   cw_addr, eng_alpha, syn_waddr, syn_wdata = 0. Reset mid-run aborts immediately, no further writes.
//  FSM: IDLE -> CLR on start. CLR (1 cyc, eng_clr=1) -> READ.
//   READ (N cyc): cw_rd=1, cw_addr=0,1,..,N-1 ascending -> WAIT.
//   WAIT (RAM_LAT+1 cyc): outstanding data drains, last engine update settles -> CAP.
//   CAP (1 cyc): syn_wr=1, syn_waddr=i, syn_wdata=eng_syn, flag |= (eng_syn!=0);
//    i==NSYN-1 -> DONE, else i<=i+1 -> CLR. DONE (1 cyc): done=1 -> IDLE.
//  eng_en = cw_rd delayed RAM_LAT cycles; eng_byte = cw_data in that cycle; exactly N eng_en per syndrome.
//  eng_clr and eng_en never high together; eng_alpha constant from CLR through CAP of syndrome i.
//  Cycles per syndrome = N+RAM_LAT+3; done asserted NSYN*(N+RAM_LAT+3)+1 cycles after the edge
//   sampling start (3329 with defaults).
//  Accepting start clears nonzero_flag and i. start while busy (incl. DONE cycle) ignored, no effect.
//  eng_alpha width rule: sum computed 9-bit, reduced mod 255 (255 -> 0).
//  syn_wr pulses exactly NSYN times per run, indices strictly ascending 0..NSYN-1.
// TESTING
//  All-zero codeword, start -> 16 writes of 0x00, nonzero_flag=0, done at cycle 3329.
//  Only byte[203]=0x01 (r(x)=1) -> S_0..S_15 all 0x01, nonzero_flag=1.
//  Only byte[202]=0x01 (r(x)=x), poly 0x11D -> S = 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26.
//  Valid encoded codeword, then same with byte[57]^=0x5A -> all 0x00 flag=0; then model-matched, flag=1.
//  start pulsed at cycles 10, 500 and on done cycle -> single run only, 16 writes, one done.
//  Reset at cycle 500 -> IDLE next cycle, busy=0, no syn_wr; RAM_LAT=2 build: address/eng_en
//   alignment checked, done at cycle 16*209+1=3345.

Source files
------------

// File: rtl/syndrome_scheduler.sv
// Sequences one shared GF(2^8) syndrome engine over a stored RS(204,188) codeword,
// producing NSYN syndromes into the syndrome register file.
module syndrome_scheduler #(
  parameter int N          = 204,
  parameter int NSYN       = 16,
  parameter int RAM_LAT    = 1,
  parameter int FIRST_ROOT = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       nonzero_flag,
  output logic       cw_rd,
  output logic [7:0] cw_addr,
  input  logic [7:0] cw_data,
  output logic       eng_clr,
  output logic       eng_en,
  output logic [7:0] eng_alpha,
  output logic [7:0] eng_byte,
  input  logic [7:0] eng_syn,
  output logic       syn_wr,
  output logic [3:0] syn_waddr,
  output logic [7:0] syn_wdata
);

  // state | meaning
  // IDLE  | waiting for start
  // CLR   | clear engine accumulator for syndrome i
  // READ  | stream N codeword bytes, address ascending
  // WAIT  | drain RAM latency, let last engine update settle
  // CAP   | write syndrome i, fold into nonzero flag
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_WAIT, S_CAP, S_DONE
  } state_t;

  localparam logic [7:0] ADDR_LAST = 8'(N - 1);
  localparam logic [3:0] IDX_LAST  = 4'(NSYN - 1);

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic [3:0]         idx, idx_nxt;
  logic               flag_nxt;
  logic [RAM_LAT-1:0] rd_pipe;
  logic [8:0]         alpha_sum;
  logic [8:0]         alpha_mod;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      nonzero_flag <= 1'b0;
      rd_pipe      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      nonzero_flag <= flag_nxt;
      rd_pipe[0]   <= cw_rd;
      for (int j = 1; j < RAM_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
  end

  // 9-bit sum so FIRST_ROOT+i wraps correctly at 255
  assign alpha_sum = 9'(FIRST_ROOT % 255) + {5'b0, idx};
  assign alpha_mod = (alpha_sum >= 9'd255) ? (alpha_sum - 9'd255) : alpha_sum;

  assign eng_en   = rd_pipe[RAM_LAT-1];
  assign eng_byte = cw_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    flag_nxt  = nonzero_flag;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    cw_rd     = 1'b0;
    cw_addr   = '0;
    eng_clr   = 1'b0;
    eng_alpha = (state == S_IDLE) ? 8'd0 : alpha_mod[7:0];
    syn_wr    = 1'b0;
    syn_waddr = '0;
    syn_wdata = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLR;
          idx_nxt   = '0;
          flag_nxt  = 1'b0;
        end
      end
      S_CLR: begin
        eng_clr   = 1'b1;
        cnt_nxt   = ADDR_LAST;
        state_nxt = S_READ;
      end
      S_READ: begin
        cw_rd   = 1'b1;
        cw_addr = ADDR_LAST - cnt;
        if (cnt == 8'd0) begin
          cnt_nxt   = 8'(RAM_LAT);
          state_nxt = S_WAIT;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt == 8'd0) state_nxt = S_CAP;
        else             cnt_nxt   = cnt - 8'd1;
      end
      S_CAP: begin
        syn_wr    = 1'b1;
        syn_waddr = idx;
        syn_wdata = eng_syn;
        flag_nxt  = nonzero_flag | (eng_syn != 8'd0);
        if (idx == IDX_LAST) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = S_CLR;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
